// File: rtl/core_mem_l1d_ctrl.sv
// core_mem_l1d_ctrl
//
// Memory-stage L1D transaction sequencer. It accepts one load/store from the
// memory stage, presents it to the L1D with a val/ack handshake, and for
// reads waits for the response data. Only one transaction is ever in flight.
// The pipeline is stalled until the transaction completes. A kill of the
// memory-stage instruction lets the transaction drain, but discards its
// result. A response timeout abandons the transaction.
//
// Ports:
//   clk, rst_n               core clock, asynchronous active-low reset
//   mem_req_*_in             request from the memory stage
//                            (cop[2]=cacheable, cop[1:0]: 00 rd, 01 wr, 1x reserved)
//   mem_kill_in              flush of the memory-stage instruction
//   mem2l1d_req_*_out        registered L1D request channel
//   l1d_req_ack_in           L1D accepted the request
//   l1d_resp_val_in/data_in  L1D read data return
//   ctrl2pipe_stall_out      freeze the memory stage and earlier stages
//   mem_rdata_out            last read data, held
//   mem_rdata_val_out        one-cycle pulse when mem_rdata_out updates
//   mem_err_out              one-cycle pulse on reserved cop or timeout
module core_mem_l1d_ctrl #(
  parameter int TMO_W   = 8,
  parameter int TMO_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req_val_in,
  input  logic [2:0]  mem_req_cop_in,
  input  logic [2:0]  mem_req_size_in,
  input  logic [31:0] mem_req_addr_in,
  input  logic [31:0] mem_req_wdata_in,
  input  logic        mem_kill_in,
  output logic        mem2l1d_req_val_out,
  input  logic        l1d_req_ack_in,
  output logic [2:0]  mem2l1d_req_cop_out,
  output logic [2:0]  mem2l1d_req_size_out,
  output logic [31:0] mem2l1d_req_addr_out,
  output logic [31:0] mem2l1d_req_wdata_out,
  input  logic        l1d_resp_val_in,
  input  logic [31:0] l1d_resp_data_in,
  output logic        ctrl2pipe_stall_out,
  output logic [31:0] mem_rdata_out,
  output logic        mem_rdata_val_out,
  output logic        mem_err_out
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

  state_e             state_q, state_d;
  logic               kill_q, kill_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic               req_val_q, req_val_d;
  logic [2:0]         cop_q, cop_d;
  logic [2:0]         size_q, size_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rdata_val_q, rdata_val_d;
  logic               err_q, err_d;
  logic               stall;

  logic cop_legal;
  logic is_write;
  logic tmo_hit;
  logic killed;

  assign cop_legal = ~mem_req_cop_in[1];
  assign is_write  = (cop_q[1:0] == 2'b01);
  assign tmo_hit   = (cnt_q == TMO_W'(TMO_CYC));
  // A kill arriving in the completion cycle itself must also discard the result.
  assign killed    = kill_q | mem_kill_in;

  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    cnt_d       = cnt_q;
    req_val_d   = req_val_q;
    cop_d       = cop_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rdata_val_d = 1'b0;
    err_d       = 1'b0;
    stall       = 1'b0;

    case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        cnt_d  = '0;
        if (mem_req_val_in && !mem_kill_in) begin
          if (cop_legal) begin
            cop_d     = mem_req_cop_in;
            size_d    = mem_req_size_in;
            addr_d    = mem_req_addr_in;
            wdata_d   = mem_req_wdata_in;
            req_val_d = 1'b1;
            state_d   = S_REQ;
            stall     = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + TMO_W'(1);
        if (mem_kill_in) kill_d = 1'b1;
        // Ack takes priority over a timeout in the same cycle: it is progress.
        if (l1d_req_ack_in) begin
          req_val_d = 1'b0;
          cnt_d     = '0;
          if (is_write) begin
            state_d = S_IDLE;
            stall   = 1'b0;
            kill_d  = 1'b0;
          end else begin
            state_d = S_RESP;
          end
        end else if (tmo_hit) begin
          req_val_d = 1'b0;
          err_d     = ~killed;
          state_d   = S_IDLE;
          stall     = 1'b0;
          kill_d    = 1'b0;
        end
      end

      S_RESP: begin
        stall = 1'b1;
        cnt_d = cnt_q + TMO_W'(1);
        if (mem_kill_in) kill_d = 1'b1;
        if (l1d_resp_val_in) begin
          if (!killed) begin
            rdata_d     = l1d_resp_data_in;
            rdata_val_d = 1'b1;
          end
          state_d = S_IDLE;
          stall   = 1'b0;
          kill_d  = 1'b0;
        end else if (tmo_hit) begin
          err_d   = ~killed;
          state_d = S_IDLE;
          stall   = 1'b0;
          kill_d  = 1'b0;
        end
      end

      default: begin
        state_d   = S_IDLE;
        req_val_d = 1'b0;
        kill_d    = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      kill_q      <= 1'b0;
      cnt_q       <= '0;
      req_val_q   <= 1'b0;
      cop_q       <= '0;
      size_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rdata_val_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      cnt_q       <= cnt_d;
      req_val_q   <= req_val_d;
      cop_q       <= cop_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rdata_val_q <= rdata_val_d;
      err_q       <= err_d;
    end
  end

  assign mem2l1d_req_val_out   = req_val_q;
  assign mem2l1d_req_cop_out   = cop_q;
  assign mem2l1d_req_size_out  = size_q;
  assign mem2l1d_req_addr_out  = addr_q;
  assign mem2l1d_req_wdata_out = wdata_q;
  assign ctrl2pipe_stall_out   = stall;
  assign mem_rdata_out         = rdata_q;
  assign mem_rdata_val_out     = rdata_val_q;
  assign mem_err_out           = err_q;

endmodule

// File: tb/tb_core_mem_l1d_ctrl.sv
module tb_core_mem_l1d_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_val_in;
  logic [2:0]  mem_req_cop_in;
  logic [2:0]  mem_req_size_in;
  logic [31:0] mem_req_addr_in;
  logic [31:0] mem_req_wdata_in;
  logic        mem_kill_in;
  logic        mem2l1d_req_val_out;
  logic        l1d_req_ack_in;
  logic [2:0]  mem2l1d_req_cop_out;
  logic [2:0]  mem2l1d_req_size_out;
  logic [31:0] mem2l1d_req_addr_out;
  logic [31:0] mem2l1d_req_wdata_out;
  logic        l1d_resp_val_in;
  logic [31:0] l1d_resp_data_in;
  logic        ctrl2pipe_stall_out;
  logic [31:0] mem_rdata_out;
  logic        mem_rdata_val_out;
  logic        mem_err_out;

  int total = 0;
  int bad   = 0;

  core_mem_l1d_ctrl #(.TMO_W(8), .TMO_CYC(4)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .mem_req_val_in        (mem_req_val_in),
    .mem_req_cop_in        (mem_req_cop_in),
    .mem_req_size_in       (mem_req_size_in),
    .mem_req_addr_in       (mem_req_addr_in),
    .mem_req_wdata_in      (mem_req_wdata_in),
    .mem_kill_in           (mem_kill_in),
    .mem2l1d_req_val_out   (mem2l1d_req_val_out),
    .l1d_req_ack_in        (l1d_req_ack_in),
    .mem2l1d_req_cop_out   (mem2l1d_req_cop_out),
    .mem2l1d_req_size_out  (mem2l1d_req_size_out),
    .mem2l1d_req_addr_out  (mem2l1d_req_addr_out),
    .mem2l1d_req_wdata_out (mem2l1d_req_wdata_out),
    .l1d_resp_val_in       (l1d_resp_val_in),
    .l1d_resp_data_in      (l1d_resp_data_in),
    .ctrl2pipe_stall_out   (ctrl2pipe_stall_out),
    .mem_rdata_out         (mem_rdata_out),
    .mem_rdata_val_out     (mem_rdata_val_out),
    .mem_err_out           (mem_err_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (mem2l1d_req_val_out !== 1'b0) begin bad++; $display("FAIL rst_val_out got=%0h exp=0", mem2l1d_req_val_out); end
    total++; if (mem2l1d_req_addr_out !== 32'h0) begin bad++; $display("FAIL rst_addr got=%0h exp=0", mem2l1d_req_addr_out); end
    total++; if (mem_rdata_out !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%0h exp=0", mem_rdata_out); end
    total++; if (mem_rdata_val_out !== 1'b0 || mem_err_out !== 1'b0) begin bad++; $display("FAIL rst_pulses got=%0h%0h exp=00", mem_rdata_val_out, mem_err_out); end
    total++; if (ctrl2pipe_stall_out !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h exp=0", ctrl2pipe_stall_out); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read;
    mem_req_val_in = 1'b1; mem_req_cop_in = 3'b100; mem_req_size_in = 3'b010;
    mem_req_addr_in = 32'h100; mem_req_wdata_in = 32'h0;
    #1;
    total++; if (ctrl2pipe_stall_out !== 1'b1) begin bad++; $display("FAIL rd_stall_cap got=%0h exp=1", ctrl2pipe_stall_out); end
    tick();
    mem_req_val_in = 1'b0;
    #1;
    total++; if (mem2l1d_req_val_out !== 1'b1) begin bad++; $display("FAIL rd_val_out got=%0h exp=1", mem2l1d_req_val_out); end
    total++; if (mem2l1d_req_addr_out !== 32'h100) begin bad++; $display("FAIL rd_addr got=%0h exp=100", mem2l1d_req_addr_out); end
    total++; if (mem2l1d_req_cop_out !== 3'b100 || mem2l1d_req_size_out !== 3'b010) begin bad++; $display("FAIL rd_cop_size got=%0h/%0h exp=4/2", mem2l1d_req_cop_out, mem2l1d_req_size_out); end
    total++; if (ctrl2pipe_stall_out !== 1'b1) begin bad++; $display("FAIL rd_stall_req0 got=%0h exp=1", ctrl2pipe_stall_out); end
    tick();
    l1d_req_ack_in = 1'b1;
    #1;
    total++; if (mem2l1d_req_val_out !== 1'b1) begin bad++; $display("FAIL rd_val_hold got=%0h exp=1", mem2l1d_req_val_out); end
    total++; if (ctrl2pipe_stall_out !== 1'b1) begin bad++; $display("FAIL rd_stall_ack got=%0h exp=1", ctrl2pipe_stall_out); end
    tick();
    l1d_req_ack_in = 1'b0;
    #1;
    total++; if (mem2l1d_req_val_out !== 1'b0) begin bad++; $display("FAIL rd_val_drop got=%0h exp=0", mem2l1d_req_val_out); end
    total++; if (ctrl2pipe_stall_out !== 1'b1) begin bad++; $display("FAIL rd_stall_resp0 got=%0h exp=1", ctrl2pipe_stall_out); end
    tick();
    total++; if (ctrl2pipe_stall_out !== 1'b1) begin bad++; $display("FAIL rd_stall_resp1 got=%0h exp=1", ctrl2pipe_stall_out); end
    tick();
    l1d_resp_val_in = 1'b1; l1d_resp_data_in = 32'hDEADBEEF;
    #1;
    total++; if (ctrl2pipe_stall_out !== 1'b0) begin bad++; $display("FAIL rd_stall_done got=%0h exp=0", ctrl2pipe_stall_out); end
    tick();
    l1d_resp_val_in = 1'b0;
    #1;
    total++; if (mem_rdata_out !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%0h exp=deadbeef", mem_rdata_out); end
    total++; if (mem_rdata_val_out !== 1'b1) begin bad++; $display("FAIL rd_pulse got=%0h exp=1", mem_rdata_val_out); end
    tick();
    total++; if (mem_rdata_val_out !== 1'b0 || mem_err_out !== 1'b0) begin bad++; $display("FAIL rd_pulse_end got=%0h%0h exp=00", mem_rdata_val_out, mem_err_out); end
  endtask

  task automatic test_write_back_to_back;
    mem_req_val_in = 1'b1; mem_req_cop_in = 3'b001; mem_req_size_in = 3'b010;
    mem_req_addr_in = 32'h200; mem_req_wdata_in = 32'h12345678;
    #1;
    total++; if (ctrl2pipe_stall_out !== 1'b1) begin bad++; $display("FAIL wr_stall_cap got=%0h exp=1", ctrl2pipe_stall_out); end
    tick();
    mem_req_val_in = 1'b0; l1d_req_ack_in = 1'b1;
    #1;
    total++; if (mem2l1d_req_val_out !== 1'b1) begin bad++; $display("FAIL wr_val_out got=%0h exp=1", mem2l1d_req_val_out); end
    total++; if (mem2l1d_req_wdata_out !== 32'h12345678 || mem2l1d_req_addr_out !== 32'h200) begin bad++; $display("FAIL wr_payload got=%0h@%0h exp=12345678@200", mem2l1d_req_wdata_out, mem2l1d_req_addr_out); end
    total++; if (ctrl2pipe_stall_out !== 1'b0) begin bad++; $display("FAIL wr_stall_ack got=%0h exp=0", ctrl2pipe_stall_out); end
    tick();
    // First IDLE cycle after completion: a new write is captured immediately.
    l1d_req_ack_in = 1'b0;
    mem_req_val_in = 1'b1; mem_req_cop_in = 3'b101; mem_req_addr_in = 32'h204; mem_req_wdata_in = 32'hAABBCCDD;
    #1;
    total++; if (mem2l1d_req_val_out !== 1'b0) begin bad++; $display("FAIL wr_val_1cyc got=%0h exp=0", mem2l1d_req_val_out); end
    total++; if (mem_rdata_val_out !== 1'b0) begin bad++; $display("FAIL wr_no_pulse got=%0h exp=0", mem_rdata_val_out); end
    total++; if (ctrl2pipe_stall_out !== 1'b1) begin bad++; $display("FAIL b2b_stall_cap got=%0h exp=1", ctrl2pipe_stall_out); end
    tick();
    mem_req_val_in = 1'b0;
    #1;
    total++; if (mem2l1d_req_val_out !== 1'b1 || mem2l1d_req_wdata_out !== 32'hAABBCCDD) begin bad++; $display("FAIL b2b_req got=%0h/%0h exp=1/aabbccdd", mem2l1d_req_val_out, mem2l1d_req_wdata_out); end
    l1d_req_ack_in = 1'b1;
    #1;
    total++; if (ctrl2pipe_stall_out !== 1'b0) begin bad++; $display("FAIL b2b_stall_ack got=%0h exp=0", ctrl2pipe_stall_out); end
    tick();
    l1d_req_ack_in = 1'b0;
    #1;
    total++; if (mem2l1d_req_val_out !== 1'b0 || ctrl2pipe_stall_out !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0h/%0h exp=0/0", mem2l1d_req_val_out, ctrl2pipe_stall_out); end
    total++; if (mem_rdata_out !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rdata_hold got=%0h exp=deadbeef", mem_rdata_out); end
  endtask

  task automatic test_kill;
    mem_req_val_in = 1'b1; mem_req_cop_in = 3'b100; mem_req_addr_in = 32'h300;
    tick();
    mem_req_val_in = 1'b0; mem_kill_in = 1'b1;
    #1;
    total++; if (ctrl2pipe_stall_out !== 1'b1) begin bad++; $display("FAIL kill_stall_req got=%0h exp=1", ctrl2pipe_stall_out); end
    tick();
    mem_kill_in = 1'b0;
    #1;
    total++; if (mem2l1d_req_val_out !== 1'b1) begin bad++; $display("FAIL kill_val_kept got=%0h exp=1", mem2l1d_req_val_out); end
    total++; if (ctrl2pipe_stall_out !== 1'b1) begin bad++; $display("FAIL kill_stall_hold got=%0h exp=1", ctrl2pipe_stall_out); end
    l1d_req_ack_in = 1'b1;
    tick();
    l1d_req_ack_in = 1'b0;
    #1;
    total++; if (mem2l1d_req_val_out !== 1'b0 || ctrl2pipe_stall_out !== 1'b1) begin bad++; $display("FAIL kill_resp got=%0h/%0h exp=0/1", mem2l1d_req_val_out, ctrl2pipe_stall_out); end
    l1d_resp_val_in = 1'b1; l1d_resp_data_in = 32'h55;
    #1;
    total++; if (ctrl2pipe_stall_out !== 1'b0) begin bad++; $display("FAIL kill_stall_done got=%0h exp=0", ctrl2pipe_stall_out); end
    tick();
    l1d_resp_val_in = 1'b0;
    #1;
    total++; if (mem_rdata_val_out !== 1'b0) begin bad++; $display("FAIL kill_no_pulse got=%0h exp=0", mem_rdata_val_out); end
    total++; if (mem_rdata_out !== 32'hDEADBEEF) begin bad++; $display("FAIL kill_rdata got=%0h exp=deadbeef", mem_rdata_out); end
    total++; if (mem_err_out !== 1'b0) begin bad++; $display("FAIL kill_no_err got=%0h exp=0", mem_err_out); end
  endtask

  task automatic test_timeout;
    mem_req_val_in = 1'b1; mem_req_cop_in = 3'b000; mem_req_addr_in = 32'h400;
    tick();
    mem_req_val_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (mem2l1d_req_val_out !== 1'b1 || mem_err_out !== 1'b0) begin bad++; $display("FAIL tmo_wait%0d got=%0h/%0h exp=1/0", i, mem2l1d_req_val_out, mem_err_out); end
      total++; if (ctrl2pipe_stall_out !== (i < 4)) begin bad++; $display("FAIL tmo_stall%0d got=%0h exp=%0h", i, ctrl2pipe_stall_out, (i < 4)); end
      if (i < 4) tick();
    end
    tick();
    total++; if (mem_err_out !== 1'b1 || mem2l1d_req_val_out !== 1'b0) begin bad++; $display("FAIL tmo_err got=%0h/%0h exp=1/0", mem_err_out, mem2l1d_req_val_out); end
    l1d_resp_val_in = 1'b1; l1d_resp_data_in = 32'h77;
    #1;
    total++; if (ctrl2pipe_stall_out !== 1'b0) begin bad++; $display("FAIL tmo_idle_stall got=%0h exp=0", ctrl2pipe_stall_out); end
    tick();
    l1d_resp_val_in = 1'b0;
    #1;
    total++; if (mem_err_out !== 1'b0 || mem_rdata_val_out !== 1'b0) begin bad++; $display("FAIL tmo_late_resp got=%0h/%0h exp=0/0", mem_err_out, mem_rdata_val_out); end
    total++; if (mem_rdata_out !== 32'hDEADBEEF) begin bad++; $display("FAIL tmo_rdata got=%0h exp=deadbeef", mem_rdata_out); end
  endtask

  task automatic test_reserved;
    mem_req_val_in = 1'b1; mem_req_cop_in = 3'b010; mem_req_addr_in = 32'h500;
    #1;
    total++; if (ctrl2pipe_stall_out !== 1'b0) begin bad++; $display("FAIL rsv_stall got=%0h exp=0", ctrl2pipe_stall_out); end
    tick();
    mem_req_val_in = 1'b0;
    #1;
    total++; if (mem2l1d_req_val_out !== 1'b0 || mem_err_out !== 1'b1) begin bad++; $display("FAIL rsv_err got=%0h/%0h exp=0/1", mem2l1d_req_val_out, mem_err_out); end
    tick();
    total++; if (mem_err_out !== 1'b0 || mem2l1d_req_val_out !== 1'b0) begin bad++; $display("FAIL rsv_err_end got=%0h/%0h exp=0/0", mem_err_out, mem2l1d_req_val_out); end
  endtask

  task automatic test_reset_in_resp;
    mem_req_val_in = 1'b1; mem_req_cop_in = 3'b100; mem_req_addr_in = 32'h600;
    tick();
    mem_req_val_in = 1'b0; l1d_req_ack_in = 1'b1;
    tick();
    l1d_req_ack_in = 1'b0;
    #1;
    total++; if (ctrl2pipe_stall_out !== 1'b1) begin bad++; $display("FAIL rr_in_resp got=%0h exp=1", ctrl2pipe_stall_out); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (mem_rdata_out !== 32'h0 || mem2l1d_req_addr_out !== 32'h0 || mem2l1d_req_cop_out !== 3'b0) begin bad++; $display("FAIL rr_async got=%0h/%0h/%0h exp=0/0/0", mem_rdata_out, mem2l1d_req_addr_out, mem2l1d_req_cop_out); end
    total++; if (ctrl2pipe_stall_out !== 1'b0 || mem2l1d_req_val_out !== 1'b0) begin bad++; $display("FAIL rr_ctrl got=%0h/%0h exp=0/0", ctrl2pipe_stall_out, mem2l1d_req_val_out); end
    #2 rst_n = 1'b1;
    tick();
    l1d_resp_val_in = 1'b1; l1d_resp_data_in = 32'h99;
    #1;
    total++; if (ctrl2pipe_stall_out !== 1'b0) begin bad++; $display("FAIL rr_stale_stall got=%0h exp=0", ctrl2pipe_stall_out); end
    tick();
    l1d_resp_val_in = 1'b0;
    #1;
    total++; if (mem_rdata_val_out !== 1'b0 || mem_rdata_out !== 32'h0) begin bad++; $display("FAIL rr_stale_resp got=%0h/%0h exp=0/0", mem_rdata_val_out, mem_rdata_out); end
    mem_req_val_in = 1'b1; mem_req_cop_in = 3'b100; mem_req_addr_in = 32'h700;
    #1;
    total++; if (ctrl2pipe_stall_out !== 1'b1) begin bad++; $display("FAIL rr_new_stall got=%0h exp=1", ctrl2pipe_stall_out); end
    tick();
    mem_req_val_in = 1'b0;
    #1;
    total++; if (mem2l1d_req_val_out !== 1'b1 || mem2l1d_req_addr_out !== 32'h700) begin bad++; $display("FAIL rr_new_req got=%0h@%0h exp=1@700", mem2l1d_req_val_out, mem2l1d_req_addr_out); end
    l1d_req_ack_in = 1'b1;
    tick();
    l1d_req_ack_in = 1'b0; l1d_resp_val_in = 1'b1; l1d_resp_data_in = 32'hCAFEF00D;
    #1;
    total++; if (ctrl2pipe_stall_out !== 1'b0) begin bad++; $display("FAIL rr_new_done got=%0h exp=0", ctrl2pipe_stall_out); end
    tick();
    l1d_resp_val_in = 1'b0;
    #1;
    total++; if (mem_rdata_val_out !== 1'b1 || mem_rdata_out !== 32'hCAFEF00D) begin bad++; $display("FAIL rr_new_data got=%0h/%0h exp=1/cafef00d", mem_rdata_val_out, mem_rdata_out); end
  endtask

  initial begin
    rst_n            = 1'b0;
    mem_req_val_in   = 1'b0;
    mem_req_cop_in   = 3'b0;
    mem_req_size_in  = 3'b0;
    mem_req_addr_in  = 32'h0;
    mem_req_wdata_in = 32'h0;
    mem_kill_in      = 1'b0;
    l1d_req_ack_in   = 1'b0;
    l1d_resp_val_in  = 1'b0;
    l1d_resp_data_in = 32'h0;

    test_reset();
    test_read();
    test_write_back_to_back();
    test_kill();
    test_timeout();
    test_reserved();
    test_reset_in_resp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
